// File: rtl/apad_mux_seq.sv
`default_nettype none
// ============================================================================
//  Module      : apad_mux_seq
//  Description : Break-before-make sequencer for an analog pad multiplexer.
//                A request opens every switch for BBM_CYC cycles and then
//                closes the selected channel. The sequencer waits SETTLE
//                cycles and then pulses ack. A request with off=1 only opens
//                the switches. Out-of-range selects are rejected with err.
//  Revision    : 1.0  initial release
// ============================================================================
module apad_mux_seq #(
  parameter int NCH      = 4,
  parameter int SEL_W    = 2,
  parameter int BBM_CYC  = 2,
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                off,
  input  logic [SEL_W-1:0]    sel,
  input  logic [SETTLE_W-1:0] settle,
  output logic [NCH-1:0]      en,
  output logic [SEL_W-1:0]    cur,
  output logic                conn,
  output logic                busy,
  output logic                ack,
  output logic                err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BREAK = 2'd1,
    S_MAKE  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Counter preload: BREAK lasts BBM_CYC cycles, so it counts down from BBM_CYC-1.
  localparam logic [3:0]     c_bbm_last = 4'(BBM_CYC - 1);
  localparam logic [SEL_W:0] c_nch      = (SEL_W + 1)'(NCH);

  state_t              r_state;
  logic [3:0]          r_bbm_cnt;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [SEL_W-1:0]    r_tgt;
  logic                r_off;

  logic [NCH-1:0]      w_hot;
  logic                w_sel_bad;
  logic                w_same;

  // One-hot enable pattern for the latched target channel.
  assign w_hot     = {{(NCH-1){1'b0}}, 1'b1} << r_tgt;
  // A select at or beyond NCH has no pad behind it.
  assign w_sel_bad = ({1'b0, sel} >= c_nch);
  // The request asks for the channel that is already closed.
  assign w_same    = !off && (sel == cur) && conn;

  // Sequencer state machine.
  // Every output is registered here, so no output has a combinational path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bbm_cnt    <= 4'd0;
      r_settle_cnt <= '0;
      r_tgt        <= '0;
      r_off        <= 1'b0;
      en           <= '0;
      cur          <= '0;
      conn         <= 1'b0;
      busy         <= 1'b0;
      ack          <= 1'b0;
      err          <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            if (!off && w_sel_bad) begin
              err <= 1'b1;
            end else if (w_same) begin
              // The channel is already closed. Skip the break phase.
              r_state <= S_DONE;
              busy    <= 1'b1;
              ack     <= 1'b1;
            end else begin
              r_state      <= S_BREAK;
              busy         <= 1'b1;
              en           <= '0;
              conn         <= 1'b0;
              r_bbm_cnt    <= c_bbm_last;
              r_tgt        <= sel;
              r_off        <= off;
              r_settle_cnt <= settle;
            end
          end
        end
        S_BREAK: begin
          if (r_bbm_cnt == 4'd0) begin
            if (r_off) begin
              r_state <= S_DONE;
              ack     <= 1'b1;
            end else begin
              en   <= w_hot;
              cur  <= r_tgt;
              conn <= 1'b1;
              if (r_settle_cnt == '0) begin
                // With zero settle time, ack goes high together with the enable.
                r_state <= S_DONE;
                ack     <= 1'b1;
              end else begin
                r_state      <= S_MAKE;
                r_settle_cnt <= r_settle_cnt - 1'b1;
              end
            end
          end else begin
            r_bbm_cnt <= r_bbm_cnt - 1'b1;
          end
        end
        S_MAKE: begin
          if (r_settle_cnt == '0) begin
            r_state <= S_DONE;
            ack     <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apad_mux_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apad_mux_seq
//  Description : Self-checking bench for apad_mux_seq (NCH=5 build). The
//                reference model keeps the accept time of the last request
//                and derives every output from time offsets.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apad_mux_seq;
  localparam int NCH   = 5;
  localparam int SEL_W = 3;
  localparam int BBM   = 2;
  localparam int SW    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic              off = 1'b0;
  logic [SEL_W-1:0]  sel = '0;
  logic [SW-1:0]     settle = '0;
  logic [NCH-1:0]    en;
  logic [SEL_W-1:0]  cur;
  logic              conn, busy, ack, err;

  apad_mux_seq #(.NCH(NCH), .SEL_W(SEL_W), .BBM_CYC(BBM), .SETTLE_W(SW)) u_dut (
    .clk(clk), .rst(rst), .req(req), .off(off), .sel(sel), .settle(settle),
    .en(en), .cur(cur), .conn(conn), .busy(busy), .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model of the last accepted request.
  // Kind codes: 0 = none, 1 = rejected, 2 = already connected, 3 = switch.
  int k_kind   = 0;
  int a_t      = 0;
  int m_tgt    = 0;
  int m_sett   = 0;
  bit m_off    = 0;
  int base_en  = 0;
  int base_cur = 0;
  int e_en = 0, e_cur = 0, e_conn = 0, e_busy = 0, e_ack = 0, e_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs in cycle c, derived from time since the last accept.
  task automatic model_eval(input int c);
    int done;
    e_en = base_en; e_cur = base_cur;
    e_busy = 0; e_ack = 0; e_err = 0;
    case (k_kind)
      1: e_err = int'(c == a_t + 1);
      2: begin e_busy = int'(c == a_t + 1); e_ack = e_busy; end
      3: begin
        done   = a_t + 1 + BBM + (m_off ? 0 : m_sett);
        e_busy = int'(c >= a_t + 1 && c <= done);
        e_ack  = int'(c == done);
        if (c <= a_t + BBM) e_en = 0;
        else if (m_off) e_en = 0;
        else begin e_en = 1 << m_tgt; e_cur = m_tgt; end
      end
      default: ;
    endcase
    e_conn = int'(e_en != 0);
  endtask

  // Drive one cycle of inputs, update the model, step a clock and compare.
  task automatic tick(input bit r, input bit q, input bit o, input int s, input int st);
    rst = r; req = q; off = o; sel = SEL_W'(s); settle = SW'(st);
    if (r) begin
      k_kind = 0; base_en = 0; base_cur = 0;
    end else if (q && e_busy == 0) begin
      base_en = e_en; base_cur = e_cur; a_t = cyc;
      m_tgt = s; m_off = o; m_sett = st;
      if (!o && s >= NCH)                    k_kind = 1;
      else if (!o && s == e_cur && e_conn != 0) k_kind = 2;
      else                                   k_kind = 3;
    end
    @(posedge clk); #1;
    cyc++;
    model_eval(cyc);
    chk("en",   int'(en),   e_en);
    chk("cur",  int'(cur),  e_cur);
    chk("conn", int'(conn), e_conn);
    chk("busy", int'(busy), e_busy);
    chk("ack",  int'(ack),  e_ack);
    chk("err",  int'(err),  e_err);
    chk("onehot0_en", int'($onehot0(en)), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    // Reset state
    tick(1'b1, 1'b0, 1'b0, 0, 0);
    tick(1'b1, 1'b0, 1'b0, 0, 0);
    // Switch to ch2 with settle 3
    tick(1'b0, 1'b1, 1'b0, 2, 3);
    idle(8);
    // Move to ch1 with zero settle: ack arrives with the enable
    tick(1'b0, 1'b1, 1'b0, 1, 0);
    idle(6);
    // Request the channel that is already connected
    tick(1'b0, 1'b1, 1'b0, 1, 5);
    idle(3);
    // Out-of-range select is rejected
    tick(1'b0, 1'b1, 1'b0, 6, 0);
    idle(2);
    // Requests while busy are ignored
    tick(1'b0, 1'b1, 1'b0, 3, 2);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 4, 0);
    idle(8);
    // Open all switches while ch3 is connected
    tick(1'b0, 1'b1, 1'b0, 3, 1);
    idle(8);
    tick(1'b0, 1'b1, 1'b1, 0, 0);
    idle(6);
    // Reset in the middle of MAKE
    tick(1'b0, 1'b1, 1'b0, 2, 10);
    idle(4);
    tick(1'b1, 1'b0, 1'b0, 0, 0);
    idle(3);
    // Maximum settle count
    tick(1'b0, 1'b1, 1'b0, 4, 255);
    idle(262);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, q, o;
      int s, st;
      r  = ($urandom_range(0, 199) == 0);
      q  = ($urandom_range(0, 2) == 0);
      o  = ($urandom_range(0, 5) == 0);
      s  = $urandom_range(0, 7);
      st = ($urandom_range(0, 49) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
      tick(r, q, o, s, st);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apad_mux_seq.md
APAD_MUX_SEQ -- requirements
Module: apad_mux_seq

Interface
REQ-001 SHALL have parameter NCH, default 4, number of analog pad channels (2..16).
REQ-002 SHALL have parameter SEL_W, default 2, select width; equals ceil(log2(NCH)).
REQ-003 SHALL have parameter BBM_CYC, default 2, break-before-make open time in cycles (1..15).
REQ-004 SHALL have parameter SETTLE_W, default 8, width of settle-count input.
REQ-005 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-007 SHALL have port REQ  input  1  switch request, sampled only in IDLE.
REQ-008 SHALL have port OFF  input  1  with REQ: open all channels, SEL ignored.
REQ-009 SHALL have port SEL  input  SEL_W  target channel index.
REQ-010 SHALL have port SETTLE  input  SETTLE_W  settle cycles after make, latched at accept.
REQ-011 SHALL have port EN  output  NCH  switch enables to analog pads, one-hot or zero.
REQ-012 SHALL have port CUR  output  SEL_W  index of connected channel.
REQ-013 SHALL have port CONN  output  1  high when any EN bit is high.
REQ-014 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-015 SHALL have port ACK  output  1  one-cycle completion pulse.
REQ-016 SHALL have port ERR  output  1  one-cycle pulse for rejected request.

Function
REQ-017 SHALL implement states IDLE, BREAK, MAKE, DONE; all outputs registered.
REQ-018 SHALL accept a request on the edge where REQ=1 and state=IDLE; REQ in any other state is ignored, not queued.
REQ-019 SHALL, for accepted REQ with OFF=0 and SEL>=NCH, pulse ERR the next cycle, stay IDLE, leave EN/CUR unchanged.
REQ-020 SHALL, for accepted REQ with OFF=0, SEL==CUR and CONN=1, pulse ACK the next cycle without entering BREAK; EN unchanged.
REQ-021 SHALL, for any other accepted request, enter BREAK the next cycle with EN=0 and hold EN=0 for exactly BBM_CYC cycles.
REQ-022 SHALL, after BREAK with OFF=0, enter MAKE: EN[SEL]=1, CUR=SEL, in cycle t+1+BBM_CYC (accept at t).
REQ-023 SHALL remain in MAKE for SETTLE cycles, then enter DONE; ACK high in cycle t+1+BBM_CYC+SETTLE, then IDLE next cycle.
REQ-024 SHALL, for SETTLE=0, assert ACK in the same cycle EN[SEL] first rises.
REQ-025 SHALL, for OFF=1, skip MAKE: after BREAK go DONE (ACK at t+1+BBM_CYC), CUR unchanged, CONN=0.
REQ-026 SHALL never assert more than one EN bit in any cycle, and never close a new channel without BBM_CYC preceding all-open cycles.
REQ-027 SHALL use a settle counter of SETTLE_W bits, no wrap; max SETTLE = 2^SETTLE_W-1 honoured exactly.
REQ-028 SHALL keep ACK and ERR mutually exclusive and never both high with BUSY=0 in the following cycle illegally (ACK cycle has BUSY=1, DONE state).

Reset
REQ-029 SHALL, with RST high at a rising edge, set state IDLE, EN=0, CUR=0, CONN=0, BUSY=0, ACK=0, ERR=0, counters 0.
REQ-030 SHALL, on RST in any state (mid-BREAK or MAKE), open all switches at that edge and drop any pending ACK.
REQ-031 SHALL give RST priority over REQ in the same cycle.

Verification
REQ-032 SHALL cover: reset, REQ SEL=2 SETTLE=3 at t=0 -> EN=0 t1..t2, EN=4'b0100 t3, ACK t6 only, CUR=2.
REQ-033 SHALL cover: connected ch2, REQ SEL=1 SETTLE=0 -> EN 0 for 2 cycles then 4'b0010 with ACK same cycle.
REQ-034 SHALL cover: REQ SEL=2 while CUR=2, CONN=1 -> ACK next cycle, no EN change, BUSY stays 0 except DONE cycle.
REQ-035 SHALL cover: NCH=5 build, REQ SEL=6 -> ERR one cycle, no state change; REQ during BUSY -> ignored.
REQ-036 SHALL cover: REQ OFF=1 while ch3 connected -> EN=0 from t1, ACK t3, CONN=0, CUR=3.
REQ-037 SHALL cover: RST asserted during MAKE -> EN=0, BUSY=0, no ACK next cycle; assertion onehot0(EN) always.
